// File: rtl/mem_wb_backend.sv
// Pipeline back end: EXE/MEM register, word-addressed data memory, MEM/WB register and write-back.
// Optional wait-state access FSM is compiled in with `define MEM_WAIT_STATES_EN.
module mem_wb_backend #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic        exe_mem_w_en,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_val_rm,
  input  logic [3:0]  exe_dest,
  output logic        mem_wb_en,
  output logic [3:0]  mem_dest,
  output logic        freeze,
  output logic        WBWriteEnable,
  output logic [31:0] WBValue,
  output logic [3:0]  WBDest
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // EXE/MEM register
  logic        r_mem_wb_en;
  logic        r_mem_r_en;
  logic        r_mem_w_en;
  logic [31:0] r_mem_alu;
  logic [31:0] r_mem_val_rm;
  logic [3:0]  r_mem_dest;

  // MEM/WB register
  logic        r_wb_en;
  logic [31:0] r_wb_value;
  logic [3:0]  r_wb_dest;

  logic [31:0] r_mem [DEPTH];

  logic        w_freeze;
  logic        w_mem_op;
  logic [31:0] w_offset;
  logic [29:0] w_word;
  logic [AW-1:0] w_index;
  logic        w_in_range;
  logic [31:0] w_rdata;
  logic        w_store;
  logic [1:0]  w_unused_offs;

  assign w_mem_op      = r_mem_r_en | r_mem_w_en;
  assign w_offset      = r_mem_alu - 32'(BASE_ADDR);
  assign w_word        = w_offset[31:2];
  assign w_index       = w_word[AW-1:0];
  assign w_unused_offs = w_offset[1:0];
  assign w_in_range    = (r_mem_alu >= 32'(BASE_ADDR)) && (w_word < 30'(DEPTH));
  assign w_rdata       = w_in_range ? r_mem[w_index] : 32'h0;

  // A load+store combination behaves as a load; the write is suppressed.
  assign w_store = r_mem_w_en & ~r_mem_r_en & w_in_range & ~w_freeze;

`ifdef MEM_WAIT_STATES_EN
  localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        r_state;
  logic [CW-1:0] r_cnt;

  assign w_freeze = w_mem_op & (r_cnt < CW'(WAIT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else if (w_freeze) begin
      r_state <= StBusy;
      r_cnt   <= (r_state == StIdle) ? CW'(1) : r_cnt + CW'(1);
    end else begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end
  end
`else
  logic [31:0] w_unused_wait;
  assign w_unused_wait = 32'(WAIT_CYCLES);
  assign w_freeze      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_wb_en  <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_mem_w_en   <= 1'b0;
      r_mem_alu    <= 32'h0;
      r_mem_val_rm <= 32'h0;
      r_mem_dest   <= 4'h0;
    end else if (!w_freeze) begin
      r_mem_wb_en  <= exe_wb_en;
      r_mem_r_en   <= exe_mem_r_en;
      r_mem_w_en   <= exe_mem_w_en;
      r_mem_alu    <= exe_alu_result;
      r_mem_val_rm <= exe_val_rm;
      r_mem_dest   <= exe_dest;
    end
  end

  // Frozen cycles push a bubble so the register file never sees a stale write twice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_en    <= 1'b0;
      r_wb_value <= 32'h0;
      r_wb_dest  <= 4'h0;
    end else if (w_freeze) begin
      r_wb_en    <= 1'b0;
      r_wb_value <= 32'h0;
      r_wb_dest  <= 4'h0;
    end else begin
      r_wb_en    <= r_mem_wb_en;
      r_wb_value <= r_mem_r_en ? w_rdata : r_mem_alu;
      r_wb_dest  <= r_mem_dest;
    end
  end

  // Contents are not reset; a reset edge abandons any pending store.
  always_ff @(posedge clk) begin
    if (rst && w_store) begin
      r_mem[w_index] <= r_mem_val_rm;
    end
  end

  assign mem_wb_en     = r_mem_wb_en;
  assign mem_dest      = r_mem_dest;
  assign freeze        = w_freeze;
  assign WBWriteEnable = r_wb_en;
  assign WBValue       = r_wb_value;
  assign WBDest        = r_wb_dest;

endmodule

// File: doc/mem_wb_backend.md
# mem_wb_backend

Back end of the ARM pipeline: EXE/MEM register, word-addressed data memory with optional wait states, MEM/WB register and write-back select. Takes the EXE stage results and produces the write-back triple (WBWriteEnable, WBValue, WBDest) that closes the loop into the decode stage's register file. It also drives freeze to stall the front end during multi-cycle memory accesses.

## Interface
- DEPTH, 64, data memory size in 32-bit words
- BASE_ADDR, 1024, byte address of memory word 0
- WAIT_CYCLES, 3, extra cycles per load/store (used only when the wait-state feature is compiled in)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (rst=0 resets on clk rising edge)
- exe_wb_en  input  1  EXE result is to be written back
- exe_mem_r_en  input  1  EXE instruction is a load (LDR)
- exe_mem_w_en  input  1  EXE instruction is a store (STR)
- exe_alu_result  input  32  ALU result / effective byte address
- exe_val_rm  input  32  store data
- exe_dest  input  4  destination register
- mem_wb_en  output  1  wb_en currently held in MEM (for hazard detection)
- mem_dest  output  4  dest currently held in MEM (for hazard detection)
- freeze  output  1  stall request to IF, ID and EXE/MEM capture
- WBWriteEnable  output  1  register-file write enable
- WBValue  output  32  write-back data
- WBDest  output  4  write-back register index

## Operation
- EXE/MEM register: captures all exe_* inputs on each edge when freeze=0; holds when freeze=1.
- Memory op present = MEM-held mem_r_en | mem_w_en. Both set at once is treated as a load; no write occurs.
- Address: word index = (alu_result - BASE_ADDR) >> 2; bits [1:0] ignored.
- Out of range means alu_result < BASE_ADDR or index >= DEPTH. An out-of-range load returns 0; an out-of-range store is dropped. Neither raises an error.
- Access FSM states:
  - IDLE: cnt=0.
  - BUSY: cnt counts 1..WAIT_CYCLES.
  - freeze = memory op present & (cnt < WAIT_CYCLES), combinational.
- Each edge with freeze=1: cnt increments (IDLE->BUSY on first), and MEM/WB loads a bubble (wb_en=0, value/dest 0).
- Completion edge is the first edge with freeze=0 for the op. At that edge:
  - the store commits (exactly once per instruction);
  - load data is captured into MEM/WB;
  - cnt returns to 0 (->IDLE);
  - EXE/MEM captures the next instruction.
- Non-memory instructions pass in one cycle. freeze stays 0 and the FSM stays IDLE.
- MEM/WB register captures wb_en, dest and value = mem_r_en ? mem_rdata : alu_result.
- WBWriteEnable, WBValue and WBDest are driven directly from MEM/WB.
- Reset:
  - EXE/MEM, MEM/WB, cnt and the FSM clear to 0/IDLE; every output reads 0.
  - Memory contents are not reset.
  - A reset during BUSY abandons the access; a pending store is not written.

## Timing
- Non-memory instruction presented at EXE in cycle N: in MEM during N+1, WB outputs valid in N+2.
- Load/store presented in cycle N: occupies MEM for WAIT_CYCLES+1 cycles (N+1 .. N+1+WAIT_CYCLES).
  - freeze=1 for the first WAIT_CYCLES of those cycles.
  - Load WB outputs valid in cycle N+2+WAIT_CYCLES.
- Store followed by a load to the same address: the load observes the stored value, because the store commits before the load enters MEM.
- Back-to-back memory ops: cnt restarts at 0 for the second op with no idle cycle between them.
- Exe_* inputs are sampled only at non-frozen edges. The upstream stage must hold them stable while freeze=1.

## Configuration
- MEM_WAIT_STATES_EN defined: wait-state FSM is present; behaviour is as above with WAIT_CYCLES.
- Not defined:
  - FSM and counter are omitted and freeze is tied to 0.
  - Every memory op completes in a single MEM cycle; load WB is valid at N+2.
  - WAIT_CYCLES is ignored.

## Test plan
- Reset: hold rst=0 for 2 cycles, with exe_* driven nonzero -> all outputs 0, freeze=0.
- ALU pass-through: exe_wb_en=1, alu_result=0x12345678, dest=5 -> two cycles later WBWriteEnable=1, WBValue=0x12345678, WBDest=5.
- Store then load: STR 0xCAFEBABE @1028, then LDR @1028 dest=3.
  - With the feature on (WAIT_CYCLES=3): freeze high 3 cycles per op.
  - Load WB shows WBValue=0xCAFEBABE, WBDest=3.
  - The store writes exactly once.
- Out of range: STR @1020 and STR @(1024+4*DEPTH), then LDR @1020 -> memory unchanged, WBValue=0.
- Reset mid-access: STR 0x1 @1032 and assert rst at cnt=1 -> after reset, LDR @1032 returns the prior value and no write occurred.
- Feature off: LDR issued -> freeze never asserted, WB valid 2 cycles after issue.
